hp_capture_rx: RTL and testbench
================================

# hp_capture_rx

Capture front end for the HP instrument's raw video: samples the instrument's 1-bit serial video with its HSYNC/VSYNC, packs pixels eight per byte, and writes the frame into the shared frame BRAM. Its write layout is the one the VGA transmit path reads back (row-major, H_ACTIVE × V_ACTIVE). A one-cycle frame-start pulse is provided to drive the transmitter's VGA_SYNC input.

## Interface
Parameters:
- H_ACTIVE, 576: captured pixels per line; must be a multiple of 8
- V_ACTIVE, 378: captured lines per frame
- H_OFFSET, 40: CLK cycles from detected HS edge to first pixel sample (≥1)
- V_OFFSET, 20: HS edges skipped after VS edge before line 0
- PIX_DIV, 2: CLK cycles per source pixel (≥1)
- ADDR_W, 15: BRAM byte-address width; 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE/8
- TIMEOUT, 4096: CLK cycles without HS edge before abort (macro-dependent)

Ports:
- CLK  in  1  capture clock, all logic on posedge
- RESET  in  1  asynchronous, active-high
- ENABLE  in  1  capture enable
- HP_HS  in  1  instrument horizontal sync, active-high, asynchronous
- HP_VS  in  1  instrument vertical sync, active-high, asynchronous
- HP_VIDEO  in  1  instrument pixel data, asynchronous
- BRAM_ADDR  out  ADDR_W  byte write address
- BRAM_DIN  out  8  packed pixels; bit 7 = leftmost
- BRAM_WE  out  1  one-cycle write strobe
- FRAME_SYNC  out  1  one-cycle pulse at start of line 0
- FRAME_DONE  out  1  one-cycle pulse after last byte of a complete frame

## Operation
- HP_HS/HP_VS/HP_VIDEO pass through a 2-flop synchronizer; HS/VS rising edges are detected on the synchronized copies.
- States: WAIT_VS → V_SKIP → WAIT_HS → H_SKIP → ACTIVE → (WAIT_HS or DONE) → WAIT_VS.
- WAIT_VS: idle until VS edge; clear line counter and address to 0.
- V_SKIP: count V_OFFSET HS edges (V_OFFSET=0 goes straight to WAIT_HS).
- WAIT_HS: on HS edge → H_SKIP; pulse FRAME_SYNC if line = 0.
- H_SKIP: count H_OFFSET cycles, then sample pixel 0 and enter ACTIVE.
- ACTIVE: sample HP_VIDEO every PIX_DIV cycles, shifting MSB-first; on every 8th sample drive BRAM_DIN, pulse BRAM_WE, then increment the address. After H_ACTIVE samples the line increments: if the line < V_ACTIVE → WAIT_HS, else DONE.
- DONE: pulse FRAME_DONE for one cycle → WAIT_VS.
- Address arithmetic: line base = line·(H_ACTIVE/8); it never exceeds H_ACTIVE·V_ACTIVE/8 − 1; no wrap.
- Early HS in ACTIVE (short line): discard partial byte, set address to next line base, line+1, go to H_SKIP (or DONE if last line).
- VS edge in any state other than WAIT_VS: abort; no FRAME_DONE; restart as V_SKIP of the new frame.
- HS and VS edge in same cycle: VS wins.
- ENABLE low: next cycle → WAIT_VS, no BRAM_WE/FRAME_* pulses; a frame in progress is abandoned.

## Timing
- Reset values: BRAM_ADDR=0, BRAM_DIN=0, BRAM_WE=0, FRAME_SYNC=0, FRAME_DONE=0, state WAIT_VS.
- Pin-to-edge-detect latency: 3 CLK cycles; every counter is referenced to the detected edge.
- Pixel k (0-based) is sampled H_OFFSET + k·PIX_DIV cycles after the detected HS edge.
- BRAM_WE rises on the cycle after the 8th sample of a byte; ADDR/DIN are valid in that same cycle and held until the next write.
- FRAME_SYNC coincides with the cycle the line-0 HS edge is detected.
- FRAME_DONE occurs one cycle after the last BRAM_WE.

## Configuration
- HP_RX_TIMEOUT_EN defined: in WAIT_HS/H_SKIP/ACTIVE, a counter reset by each HS edge aborts to WAIT_VS once it reaches TIMEOUT cycles, with no FRAME_DONE.
- Undefined: no watchdog; the block waits indefinitely for HS; the TIMEOUT parameter is unused.

## Structure
- Shared package hp2vga_pkg: state enum, default H_ACTIVE/V_ACTIVE geometry constants (shared with the transmitter address math).
- Sub-module sync_edge (2-flop synchronizer + rising-edge detector), instantiated three times with edge output unused for video.

## Test plan
- Bench params H_ACTIVE=16, V_ACTIVE=4, H_OFFSET=3, V_OFFSET=1, PIX_DIV=2, TIMEOUT=64.
- Full frame, video pattern 0xA5,0x3C per line → 8 writes at ADDR 0..7 with DIN A5,3C repeated; one FRAME_SYNC and one FRAME_DONE.
- Short line 2: HS after 10 pixels → one write for line 2 (ADDR 4), next write at ADDR 6; FRAME_DONE still pulses.
- VS pulse during line 1 → no FRAME_DONE; the next frame restarts at ADDR 0 with FRAME_SYNC.
- ENABLE dropped mid-line → zero writes afterwards; re-enabled before VS → a normal frame.
- RESET asserted mid-ACTIVE → all outputs 0 immediately.
- With HP_RX_TIMEOUT_EN, HS stopped after line 1 → abort at 64 cycles and no FRAME_DONE. Without the macro → the block stays waiting.

Source files
------------

// File: rtl/hp2vga_pkg.sv
// Shared HP-to-VGA definitions: capture FSM states and default frame geometry
// used by both the capture front end and the VGA transmit address math.
package hp2vga_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_VS = 3'd0,
    ST_V_SKIP  = 3'd1,
    ST_WAIT_HS = 3'd2,
    ST_H_SKIP  = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_DONE    = 3'd5
  } hp_rx_state_e;

  localparam int HP_H_ACTIVE = 576;
  localparam int HP_V_ACTIVE = 378;

  // Frame buffer stores eight 1-bit pixels per byte, row-major.
  function automatic int hp_bytes_per_line(input int h_active);
    return h_active / 8;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered level/rising-edge stage.
// Pin-to-output latency is three clocks for both the level and the edge pulse.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_q;
  logic r_rise;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_q    <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_q    <= r_sync;
      r_rise <= r_sync & ~r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_rise;

endmodule

// File: rtl/hp_capture_rx.sv
// HP raw-video capture: syncs HS/VS/video, packs 8 pixels per byte MSB-first and
// writes the frame row-major into BRAM. Optional HS watchdog: HP_RX_TIMEOUT_EN.
module hp_capture_rx
  import hp2vga_pkg::*;
#(
  parameter int H_ACTIVE = HP_H_ACTIVE,
  parameter int V_ACTIVE = HP_V_ACTIVE,
  parameter int H_OFFSET = 40,
  parameter int V_OFFSET = 20,
  parameter int PIX_DIV  = 2,
  parameter int ADDR_W   = 15,
  parameter int TIMEOUT  = 4096
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              HP_HS,
  input  logic              HP_VS,
  input  logic              HP_VIDEO,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [7:0]        BRAM_DIN,
  output logic              BRAM_WE,
  output logic              FRAME_SYNC,
  output logic              FRAME_DONE
);

  localparam int PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] C_BPL       = ADDR_W'(hp_bytes_per_line(H_ACTIVE));
  localparam logic [15:0]       C_HOFF_LAST = 16'(H_OFFSET - 1);
  localparam logic [15:0]       C_PDIV_LAST = 16'(PIX_DIV - 1);
  localparam logic [15:0]       C_VOFF_LAST = 16'(V_OFFSET - 1);
  localparam logic [PIX_W-1:0]  C_PIX_LAST  = PIX_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] C_LINES     = LINE_W'(V_ACTIVE);

  logic w_hs_edge, w_vs_edge, w_video;
  logic w_hs_lvl, w_vs_lvl, w_vid_rise;
  logic w_wdog_exp;
  logic w_unused;

  sync_edge u_sync_hs  (.i_clk(CLK), .i_rst(RESET), .i_d(HP_HS),    .o_q(w_hs_lvl), .o_rise(w_hs_edge));
  sync_edge u_sync_vs  (.i_clk(CLK), .i_rst(RESET), .i_d(HP_VS),    .o_q(w_vs_lvl), .o_rise(w_vs_edge));
  sync_edge u_sync_vid (.i_clk(CLK), .i_rst(RESET), .i_d(HP_VIDEO), .o_q(w_video),  .o_rise(w_vid_rise));

  hp_rx_state_e      r_state;
  logic [15:0]       r_cnt;
  logic [PIX_W-1:0]  r_pix;
  logic [LINE_W-1:0] r_line;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_waddr;
  logic [6:0]        r_shift;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_din;
  logic              r_we;
  logic              r_done;

  logic [7:0]        w_byte;
  logic [LINE_W-1:0] w_line_inc;
  logic              w_last_line;
  logic [ADDR_W-1:0] w_next_base;

  assign w_byte      = {r_shift, w_video};
  assign w_line_inc  = r_line + LINE_W'(1);
  assign w_last_line = (w_line_inc == C_LINES);
  assign w_next_base = r_base + C_BPL;

`ifdef HP_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_wdog;
  logic            w_in_line;

  assign w_in_line  = (r_state == ST_WAIT_HS) || (r_state == ST_H_SKIP) || (r_state == ST_ACTIVE);
  assign w_wdog_exp = w_in_line && !w_hs_edge && (r_wdog == C_TO_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_wdog <= '0;
    else if (!ENABLE || !w_in_line || w_hs_edge)
      r_wdog <= '0;
    else
      r_wdog <= r_wdog + TO_W'(1);
  end

  assign w_unused = &{1'b0, w_hs_lvl, w_vs_lvl, w_vid_rise};
`else
  assign w_wdog_exp = 1'b0;
  assign w_unused   = &{1'b0, w_hs_lvl, w_vs_lvl, w_vid_rise, (TIMEOUT != 0)};
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_WAIT_VS;
      r_cnt   <= '0;
      r_pix   <= '0;
      r_line  <= '0;
      r_base  <= '0;
      r_waddr <= '0;
      r_shift <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (!ENABLE) begin
        r_state <= ST_WAIT_VS;
      end else if (w_vs_edge) begin
        // A VS edge always starts a new frame, even mid-frame (aborting the old one).
        r_state <= (V_OFFSET == 0) ? ST_WAIT_HS : ST_V_SKIP;
        r_cnt   <= '0;
        r_pix   <= '0;
        r_line  <= '0;
        r_base  <= '0;
        r_waddr <= '0;
      end else if (w_wdog_exp) begin
        r_state <= ST_WAIT_VS;
      end else begin
        case (r_state)
          ST_WAIT_VS: begin
            r_cnt   <= '0;
            r_pix   <= '0;
            r_line  <= '0;
            r_base  <= '0;
            r_waddr <= '0;
          end
          ST_V_SKIP: begin
            if (w_hs_edge) begin
              if (r_cnt == C_VOFF_LAST) begin
                r_cnt   <= '0;
                r_state <= ST_WAIT_HS;
              end else begin
                r_cnt <= r_cnt + 16'd1;
              end
            end
          end
          ST_WAIT_HS: begin
            if (w_hs_edge) begin
              r_cnt   <= '0;
              r_state <= ST_H_SKIP;
            end
          end
          ST_H_SKIP: begin
            if (r_cnt == C_HOFF_LAST) begin
              r_shift <= w_byte[6:0];
              r_pix   <= PIX_W'(1);
              r_cnt   <= '0;
              r_state <= ST_ACTIVE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          ST_ACTIVE: begin
            if (w_hs_edge) begin
              // Short line: drop the partial byte and realign to the next line base.
              r_line  <= w_line_inc;
              r_base  <= w_next_base;
              r_waddr <= w_next_base;
              r_pix   <= '0;
              r_cnt   <= '0;
              r_state <= w_last_line ? ST_DONE : ST_H_SKIP;
            end else if (r_cnt == C_PDIV_LAST) begin
              r_cnt   <= '0;
              r_shift <= w_byte[6:0];
              r_pix   <= r_pix + PIX_W'(1);
              if (r_pix[2:0] == 3'd7) begin
                r_we    <= 1'b1;
                r_addr  <= r_waddr;
                r_din   <= w_byte;
                r_waddr <= r_waddr + ADDR_W'(1);
              end
              if (r_pix == C_PIX_LAST) begin
                r_pix   <= '0;
                r_line  <= w_line_inc;
                r_base  <= w_next_base;
                r_state <= w_last_line ? ST_DONE : ST_WAIT_HS;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          ST_DONE: begin
            r_done  <= 1'b1;
            r_state <= ST_WAIT_VS;
          end
          default: r_state <= ST_WAIT_VS;
        endcase
      end
    end
  end

  assign BRAM_ADDR  = r_addr;
  assign BRAM_DIN   = r_din;
  assign BRAM_WE    = r_we;
  assign FRAME_DONE = r_done;
  // Combinational so the pulse lands in the same cycle the line-0 HS edge is seen.
  assign FRAME_SYNC = (r_state == ST_WAIT_HS) && w_hs_edge && !w_vs_edge && (r_line == '0);

endmodule

// File: tb/tb_hp_capture_rx.sv
// Directed/randomized bench for hp_capture_rx on a 16x4 frame; expected BRAM writes
// are derived from the pixels driven on each line (also honours HP_RX_TIMEOUT_EN).
module tb_hp_capture_rx;

  localparam int H = 16, V = 4, HO = 3, VO = 1, PD = 2, TO = 64, AW = 4;
  localparam int LINE_CYC = 44;
  localparam int BPL = H / 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          ENABLE = 1'b0;
  logic          HP_HS = 1'b0;
  logic          HP_VS = 1'b0;
  logic          HP_VIDEO = 1'b0;
  logic [AW-1:0] BRAM_ADDR;
  logic [7:0]    BRAM_DIN;
  logic          BRAM_WE;
  logic          FRAME_SYNC;
  logic          FRAME_DONE;

  hp_capture_rx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_OFFSET(HO), .V_OFFSET(VO),
    .PIX_DIV(PD), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .HP_HS(HP_HS), .HP_VS(HP_VS), .HP_VIDEO(HP_VIDEO),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_DIN(BRAM_DIN), .BRAM_WE(BRAM_WE),
    .FRAME_SYNC(FRAME_SYNC), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [AW+7:0] got_q[$];
  logic [AW+7:0] exp_q[$];
  int  n_sync = 0, n_done = 0;
  time t_sync = 0, t_first_we = 0, t_last_we = 0, t_done = 0, t_hs = 0, t_hs0 = 0;

  always @(negedge CLK) begin
    if (!RESET) begin
      if (BRAM_WE) begin
        if (got_q.size() == 0) t_first_we = $time;
        t_last_we = $time;
        got_q.push_back({BRAM_ADDR, BRAM_DIN});
        $display("write addr=%0d din=%02h", BRAM_ADDR, BRAM_DIN);
      end
      if (FRAME_SYNC) begin n_sync++; t_sync = $time; end
      if (FRAME_DONE) begin n_done++; t_done = $time; end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One source line: HS pulse at step 0, pixel k held on video for steps HO+k*PD .. +PD-1.
  task automatic drive_line(input logic [15:0] bits, input int ncyc);
    for (int j = 0; j < ncyc; j++) begin
      @(negedge CLK);
      HP_HS = (j < 2);
      if (j == 0) t_hs = $time;
      if (j >= HO && (j - HO) / PD < H) HP_VIDEO = bits[H - 1 - (j - HO) / PD];
      else HP_VIDEO = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge CLK);
      HP_HS = 1'b0;
      HP_VS = 1'b0;
      HP_VIDEO = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic vs_pulse();
    @(negedge CLK);
    HP_VS = 1'b1;
    HP_HS = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    idle(6);
  endtask

  task automatic frame_start();
    vs_pulse();
    drive_line(16'($urandom), LINE_CYC);
  endtask

  // Reference: the first npix pixels of line l land in whole bytes at l*BPL + b.
  task automatic expect_line(input int l, input logic [15:0] bits, input int npix);
    for (int b = 0; b < npix / 8; b++) begin
      logic [AW-1:0] a;
      a = AW'(l * BPL + b);
      exp_q.push_back({a, bits[15 - 8 * b -: 8]});
    end
  endtask

  task automatic end_frame(input string tag, input int n_idle, input int exp_sync, input int exp_done);
    int n;
    idle(n_idle);
    check($sformatf("%s_nwrites", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check($sformatf("%s_sync", tag), n_sync, exp_sync);
    check($sformatf("%s_done", tag), n_done, exp_done);
    got_q.delete();
    exp_q.delete();
    n_sync = 0;
    n_done = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [15:0] b [4];

    repeat (3) @(negedge CLK);
    check("rst_addr", BRAM_ADDR, 0);
    check("rst_din", BRAM_DIN, 0);
    check("rst_we", BRAM_WE, 0);
    check("rst_sync", FRAME_SYNC, 0);
    check("rst_done", FRAME_DONE, 0);
    RESET = 1'b0;
    ENABLE = 1'b1;
    idle(5);

    // A: fixed A5/3C pattern, plus latency checks
    frame_start();
    for (int l = 0; l < V; l++) begin
      drive_line(16'hA53C, LINE_CYC);
      if (l == 0) t_hs0 = t_hs;
      expect_line(l, 16'hA53C, H);
    end
    end_frame("A", 20, 1, 1);
    check("A_sync_lat", 32'(t_sync - t_hs0), 30);
    check("A_we_lat", 32'(t_first_we - t_hs0), 10 * (3 + HO + 7 * PD + 1));
    check("A_done_lat", 32'(t_done - t_last_we), 10);

    // B: random data, line 2 cut short after 10 pixels
    frame_start();
    for (int l = 0; l < V; l++) begin
      b[l] = 16'($urandom);
      drive_line(b[l], (l == 2) ? 23 : LINE_CYC);
      expect_line(l, b[l], (l == 2) ? 10 : H);
    end
    end_frame("B", 20, 1, 1);

    // C: VS arrives during line 1 after 11 pixels; D: restarted frame
    frame_start();
    b[0] = 16'($urandom);
    b[1] = 16'($urandom);
    drive_line(b[0], LINE_CYC);
    expect_line(0, b[0], H);
    drive_line(b[1], 24);
    expect_line(1, b[1], 11);
    vs_pulse();
    end_frame("C", 0, 1, 0);
    drive_line(16'($urandom), LINE_CYC);
    for (int l = 0; l < V; l++) begin
      b[l] = 16'($urandom);
      drive_line(b[l], LINE_CYC);
      expect_line(l, b[l], H);
    end
    end_frame("D", 20, 1, 1);

    // E: ENABLE dropped in line 1, restored before line 3; F: next normal frame
    frame_start();
    b[0] = 16'($urandom);
    drive_line(b[0], LINE_CYC);
    expect_line(0, b[0], H);
    drive_line(16'($urandom), 12);
    ENABLE = 1'b0;
    idle(LINE_CYC - 12);
    drive_line(16'($urandom), LINE_CYC);
    ENABLE = 1'b1;
    drive_line(16'($urandom), LINE_CYC);
    end_frame("E", 20, 1, 0);
    frame_start();
    for (int l = 0; l < V; l++) begin
      b[l] = 16'($urandom);
      drive_line(b[l], LINE_CYC);
      expect_line(l, b[l], H);
    end
    end_frame("F", 20, 1, 1);

    // G: asynchronous reset in the middle of line 1
    frame_start();
    b[0] = 16'($urandom);
    b[1] = 16'($urandom);
    drive_line(b[0], LINE_CYC);
    expect_line(0, b[0], H);
    drive_line(b[1], 24);
    expect_line(1, b[1], 11);
    @(negedge CLK);
    HP_HS = 1'b0;
    check("G_pre_addr", BRAM_ADDR, BPL);
    check("G_pre_din", BRAM_DIN, b[1][15:8]);
    RESET = 1'b1;
    #1;
    check("G_rst_addr", BRAM_ADDR, 0);
    check("G_rst_din", BRAM_DIN, 0);
    check("G_rst_we", BRAM_WE, 0);
    check("G_rst_sync", FRAME_SYNC, 0);
    check("G_rst_done", FRAME_DONE, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    end_frame("G", 10, 1, 0);

    // H: HS stops after line 1 for longer than TIMEOUT, then resumes
    frame_start();
    for (int l = 0; l < V; l++) begin
      b[l] = 16'($urandom);
      drive_line(b[l], LINE_CYC);
      if (l == 1) idle(100);
`ifdef HP_RX_TIMEOUT_EN
      if (l < 2) expect_line(l, b[l], H);
`else
      expect_line(l, b[l], H);
`endif
    end
`ifdef HP_RX_TIMEOUT_EN
    end_frame("H", 20, 1, 0);
`else
    end_frame("H", 20, 1, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
